fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction fetch stage that sits directly upstream of the processor datapath. It replaces the combinational instruction-memory read with a handshaked fetch engine. The unit issues sequential word requests to an instruction memory of variable latency and buffers returned words with their PCs in a small prefetch queue. It presents the queue head to decode through a valid/ready interface and flushes and refetches when the datapath signals a taken branch.

## Interface
- DEPTH, 4, prefetch queue entries; power of two, ≥2
- RESET_PC, 32'h0, first fetch address after reset; word aligned
- CLK  in  1  clock, all state on rising edge
- RST_X  in  1  asynchronous, active-low reset
- IM_REQ  out  1  request to instruction memory, registered
- IM_ADDR  out  32  byte address of request, registered, bits [1:0]=0
- IM_ACK  in  1  memory completes current request this cycle
- IM_RDATA  in  32  instruction word, valid only when IM_ACK=1
- IF_VALID  out  1  queue head holds a valid instruction
- IF_PC  out  32  PC of queue head
- IF_IR  out  32  instruction word of queue head
- IF_READY  in  1  datapath consumes head this cycle
- BR_TAKEN  in  1  redirect: flush queue, fetch from BR_TARGET
- BR_TARGET  in  32  redirect address, word aligned

## Operation
- Reset values: IM_REQ=0, IM_ADDR=RESET_PC, queue empty (IF_VALID=0), state IDLE, fetch PC=RESET_PC.
- States:
  - IDLE: no request outstanding. Go to FETCH (IM_REQ<=1, IM_ADDR<=fetch PC) when count<DEPTH and no BR_TAKEN.
  - FETCH: request outstanding.
  - DRAIN: the outstanding request was orphaned by a redirect, so its data will be discarded.
- Memory rule: once IM_REQ=1, IM_REQ and IM_ADDR hold stable until a cycle with IM_ACK=1. There is never more than one request outstanding. IM_ACK while IM_REQ=0 is ignored.
- FETCH with IM_ACK:
  - Enqueue {IM_ADDR, IM_RDATA} and set fetch PC to IM_ADDR+4.
  - If count_next<DEPTH, stay FETCH with IM_ADDR<=IM_ADDR+4. Otherwise go to IDLE with IM_REQ<=0.
- Pop: when IF_VALID&IF_READY, the head is consumed at the clock edge.
- count_next = count + enq − pop. Simultaneous enqueue and pop on a non-empty queue leaves the count unchanged.
- Enqueue into a full queue cannot occur, because a request is issued only when count<DEPTH. The bench must assert this never happens.
- BR_TAKEN (highest priority):
  - Queue is emptied. Pop and enqueue in the same cycle are discarded.
  - Fetch PC<=BR_TARGET.
  - If FETCH without IM_ACK: go to DRAIN; IM_REQ stays high at the old address.
  - If FETCH with IM_ACK, or IDLE: go to FETCH with IM_ADDR<=BR_TARGET.
  - If DRAIN: stay DRAIN and update the target.
- DRAIN with IM_ACK: data discarded; go to FETCH with IM_ADDR<=fetch PC.
- PC arithmetic is 32-bit modulo. 32'hFFFFFFFC+4 wraps to 0.
- Reset asserted mid-operation immediately returns all state to reset values. This includes a request in flight, which is abandoned.

## Timing
- IF_VALID, IF_PC and IF_IR are combinational from the queue head. All other outputs are registered.
- First request: IM_REQ=1 in the cycle after the first rising edge with RST_X=1.
- Zero-wait memory (IM_ACK=1 in the same cycle as IM_REQ): the word is at the head one cycle after the request cycle. Steady throughput is 1 instruction/cycle.
- Memory with W wait cycles: one enqueue every W+1 cycles.
- Redirect latency: BR_TAKEN at edge N, with no request outstanding or ACK at N, gives IM_ADDR=BR_TARGET in cycle N+1. The target instruction is visible at N+2 with zero-wait memory.

## Structure
- Shared package holds:
  - the state enum (IDLE, FETCH, DRAIN)
  - the word width (32) and PC increment (4)
  - the entry typedef {pc[31:0], ir[31:0]}
- Sub-module fetch_fifo: DEPTH-entry circular buffer of entries.
  - Inputs: enq, deq, flush.
  - Outputs: head entry, count.
  - Pointers are log2(DEPTH) bits and wrap naturally.
  - flush overrides enq and deq.
- The fetch_unit top holds the FSM, the fetch PC and the memory-side registers.

## Test plan
- Reset then zero-wait memory, IF_READY=1 → IM_ADDR 0,4,8,… on consecutive cycles. IF_PC sequence 0,4,8 with matching IF_IR from the cycle after each request.
- IF_READY=0, DEPTH=4 → exactly 4 ACKs accepted, IM_REQ drops to 0, IF_PC=0 at head. Raising IF_READY for one cycle → one new request at address 16.
- Memory with 3 wait cycles, BR_TAKEN with BR_TARGET=32'h40 during the wait:
  - IM_ADDR holds the old address until ACK.
  - The old data is not enqueued.
  - The next IM_ADDR is 32'h40, and the first IF_PC after the redirect is 32'h40.
- BR_TAKEN coincident with IM_ACK and pop on a non-empty queue → queue empty next cycle, IM_ADDR=BR_TARGET, no stale entry ever appears on IF_PC.
- RESET_PC=32'hFFFFFFF8 → IF_PC sequence FFFFFFF8, FFFFFFFC, 00000000.
- RST_X pulsed low while in FETCH with 2 entries queued → IF_VALID=0 and IM_REQ=0 immediately. Fetch restarts at RESET_PC after release.

Source files
------------

// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch engine.
package fetch_unit_pkg;

    localparam int          WORD_W = 32;
    localparam logic [31:0] PC_INC = 32'd4;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        DRAIN
    } fetch_state_e;

    typedef struct packed {
        logic [WORD_W-1:0] pc;
        logic [WORD_W-1:0] ir;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_unit_fifo.sv
// Circular prefetch buffer holding {pc, ir} entries; flush overrides enq/deq.
module fetch_fifo
    import fetch_unit_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     CLK,
    input  logic                     RST_X,
    input  logic                     enq,
    input  logic                     deq,
    input  logic                     flush,
    input  fetch_entry_t             enq_entry,
    output fetch_entry_t             head,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    fetch_entry_t           mem [DEPTH];
    logic [PTR_W-1:0]       rd_ptr;
    logic [PTR_W-1:0]       wr_ptr;

    always_ff @(posedge CLK or negedge RST_X) begin
        if (!RST_X) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (enq) wr_ptr <= wr_ptr + PTR_W'(1);
            if (deq) rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count + CNT_W'(enq) - CNT_W'(deq);
        end
    end

    // Storage needs no reset; count gates visibility of every entry.
    always_ff @(posedge CLK) begin
        if (enq && !flush) mem[wr_ptr] <= enq_entry;
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/fetch_unit.sv
// Handshaked instruction fetch engine: one outstanding memory request,
// prefetch queue toward decode, flush-and-refetch on taken branch.
//
//   state | meaning
//   IDLE  | no request outstanding; issue when queue has room
//   FETCH | request outstanding, its data will be enqueued
//   DRAIN | request orphaned by a redirect; its data is dropped
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic                CLK,
    input  logic                RST_X,
    output logic                IM_REQ,
    output logic [WORD_W-1:0]   IM_ADDR,
    input  logic                IM_ACK,
    input  logic [WORD_W-1:0]   IM_RDATA,
    output logic                IF_VALID,
    output logic [WORD_W-1:0]   IF_PC,
    output logic [WORD_W-1:0]   IF_IR,
    input  logic                IF_READY,
    input  logic                BR_TAKEN,
    input  logic [WORD_W-1:0]   BR_TARGET
);

    localparam int              CNT_W   = $clog2(DEPTH) + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    fetch_state_e       state;
    logic [WORD_W-1:0]  fetch_pc;
    logic [CNT_W-1:0]   count;
    logic [CNT_W-1:0]   count_next;
    logic               enq;
    logic               pop;
    fetch_entry_t       head;
    fetch_entry_t       enq_entry;

    assign enq        = (state == FETCH) && IM_ACK && !BR_TAKEN;
    assign pop        = IF_VALID && IF_READY && !BR_TAKEN;
    assign count_next = count + CNT_W'(enq) - CNT_W'(pop);
    assign enq_entry  = '{pc: IM_ADDR, ir: IM_RDATA};

    fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .CLK       (CLK),
        .RST_X     (RST_X),
        .enq       (enq),
        .deq       (pop),
        .flush     (BR_TAKEN),
        .enq_entry (enq_entry),
        .head      (head),
        .count     (count)
    );

    assign IF_VALID = (count != '0);
    assign IF_PC    = head.pc;
    assign IF_IR    = head.ir;

    always_ff @(posedge CLK or negedge RST_X) begin
        if (!RST_X) begin
            state    <= IDLE;
            IM_REQ   <= 1'b0;
            IM_ADDR  <= RESET_PC;
            fetch_pc <= RESET_PC;
        end else begin
            unique case (state)
                IDLE: begin
                    if (BR_TAKEN) begin
                        state    <= FETCH;
                        IM_REQ   <= 1'b1;
                        IM_ADDR  <= BR_TARGET;
                        fetch_pc <= BR_TARGET;
                    end else if (count < DEPTH_C) begin
                        state   <= FETCH;
                        IM_REQ  <= 1'b1;
                        IM_ADDR <= fetch_pc;
                    end
                end
                FETCH: begin
                    if (BR_TAKEN) begin
                        fetch_pc <= BR_TARGET;
                        if (IM_ACK) IM_ADDR <= BR_TARGET;
                        else        state   <= DRAIN;
                    end else if (IM_ACK) begin
                        fetch_pc <= IM_ADDR + PC_INC;
                        if (count_next < DEPTH_C) begin
                            IM_ADDR <= IM_ADDR + PC_INC;
                        end else begin
                            state  <= IDLE;
                            IM_REQ <= 1'b0;
                        end
                    end
                end
                DRAIN: begin
                    // A redirect landing on the draining ack wins over the older target.
                    if (BR_TAKEN) fetch_pc <= BR_TARGET;
                    if (IM_ACK) begin
                        state   <= FETCH;
                        IM_ADDR <= BR_TAKEN ? BR_TARGET : fetch_pc;
                    end
                end
                default: begin
                    state  <= IDLE;
                    IM_REQ <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit with a variable-latency memory model.
module tb_fetch_unit;

    logic        CLK;
    logic        RST_X;
    logic        IM_REQ;
    logic [31:0] IM_ADDR;
    logic        IM_ACK;
    logic [31:0] IM_RDATA;
    logic        IF_VALID;
    logic [31:0] IF_PC;
    logic [31:0] IF_IR;
    logic        IF_READY;
    logic        BR_TAKEN;
    logic [31:0] BR_TARGET;

    logic        im_req2;
    logic [31:0] im_addr2;
    logic        im_ack2;
    logic [31:0] im_rdata2;
    logic        if_valid2;
    logic [31:0] if_pc2;
    logic [31:0] if_ir2;

    int checks;
    int failures;
    int mem_wait;
    int wait_cnt;
    int ack_cnt;
    int full_enq_cnt;

    fetch_unit #(.DEPTH(4), .RESET_PC(32'h0)) u_dut (
        .CLK(CLK), .RST_X(RST_X),
        .IM_REQ(IM_REQ), .IM_ADDR(IM_ADDR), .IM_ACK(IM_ACK), .IM_RDATA(IM_RDATA),
        .IF_VALID(IF_VALID), .IF_PC(IF_PC), .IF_IR(IF_IR), .IF_READY(IF_READY),
        .BR_TAKEN(BR_TAKEN), .BR_TARGET(BR_TARGET)
    );

    fetch_unit #(.DEPTH(4), .RESET_PC(32'hFFFF_FFF8)) u_dut_wrap (
        .CLK(CLK), .RST_X(RST_X),
        .IM_REQ(im_req2), .IM_ADDR(im_addr2), .IM_ACK(im_ack2), .IM_RDATA(im_rdata2),
        .IF_VALID(if_valid2), .IF_PC(if_pc2), .IF_IR(if_ir2), .IF_READY(1'b1),
        .BR_TAKEN(1'b0), .BR_TARGET(32'h0)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hA5C3_0F96;
    endfunction

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Memory model: mem_wait idle cycles, then ack with a word derived from the address.
    always @(negedge CLK) begin
        if (IM_REQ) begin
            if (wait_cnt >= mem_wait) begin
                IM_ACK   = 1'b1;
                IM_RDATA = mem_word(IM_ADDR);
                wait_cnt = 0;
            end else begin
                IM_ACK   = 1'b0;
                wait_cnt = wait_cnt + 1;
            end
        end else begin
            IM_ACK   = 1'b0;
            wait_cnt = 0;
        end
        im_ack2   = im_req2;
        im_rdata2 = mem_word(im_addr2);
    end

    always @(posedge CLK or negedge RST_X) begin
        if (!RST_X)                ack_cnt <= 0;
        else if (IM_REQ && IM_ACK) ack_cnt <= ack_cnt + 1;
    end

    always @(posedge CLK) begin
        if (RST_X && u_dut.enq && u_dut.count == 3'd4)           full_enq_cnt <= full_enq_cnt + 1;
        if (RST_X && u_dut_wrap.enq && u_dut_wrap.count == 3'd4) full_enq_cnt <= full_enq_cnt + 1;
    end

    task automatic reset_dut();
        @(negedge CLK);
        RST_X = 1'b0;
        repeat (2) @(negedge CLK);
        RST_X = 1'b1;
        @(negedge CLK);
    endtask

    task automatic test_reset();
        @(negedge CLK);
        checks++; if (IM_REQ !== 1'b0) begin failures++; $display("FAIL reset_req got=%b exp=0", IM_REQ); end
        checks++; if (IM_ADDR !== 32'h0) begin failures++; $display("FAIL reset_addr got=%h exp=0", IM_ADDR); end
        checks++; if (IF_VALID !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", IF_VALID); end
        checks++; if (im_addr2 !== 32'hFFFF_FFF8) begin failures++; $display("FAIL reset_addr_wrap got=%h exp=fffffff8", im_addr2); end
        RST_X = 1'b1;
        @(negedge CLK);
        checks++; if (IM_REQ !== 1'b1 || IM_ADDR !== 32'h0) begin failures++; $display("FAIL first_req got=%b/%h exp=1/0", IM_REQ, IM_ADDR); end
    endtask

    task automatic test_zero_wait();
        mem_wait = 0;
        IF_READY = 1'b1;
        reset_dut();
        checks++; if (IM_REQ !== 1'b1 || IM_ADDR !== 32'h0 || IF_VALID !== 1'b0) begin
            failures++; $display("FAIL zw_first got=%b/%h/%b exp=1/0/0", IM_REQ, IM_ADDR, IF_VALID); end
        for (int k = 1; k <= 5; k++) begin
            @(negedge CLK);
            checks++; if (IM_ADDR !== 32'(4 * k)) begin failures++; $display("FAIL zw_addr[%0d] got=%h exp=%h", k, IM_ADDR, 32'(4 * k)); end
            checks++; if (IF_VALID !== 1'b1 || IF_PC !== 32'(4 * (k - 1))) begin
                failures++; $display("FAIL zw_pc[%0d] got=%b/%h exp=1/%h", k, IF_VALID, IF_PC, 32'(4 * (k - 1))); end
            checks++; if (IF_IR !== mem_word(32'(4 * (k - 1)))) begin
                failures++; $display("FAIL zw_ir[%0d] got=%h exp=%h", k, IF_IR, mem_word(32'(4 * (k - 1)))); end
        end
    endtask

    task automatic test_backpressure();
        mem_wait = 0;
        IF_READY = 1'b0;
        reset_dut();
        repeat (4) @(negedge CLK);
        checks++; if (IM_REQ !== 1'b0) begin failures++; $display("FAIL bp_req_drop got=%b exp=0", IM_REQ); end
        checks++; if (IF_VALID !== 1'b1 || IF_PC !== 32'h0) begin failures++; $display("FAIL bp_head got=%b/%h exp=1/0", IF_VALID, IF_PC); end
        repeat (3) @(negedge CLK);
        checks++; if (IM_REQ !== 1'b0 || ack_cnt !== 4) begin failures++; $display("FAIL bp_acks got=%b/%0d exp=0/4", IM_REQ, ack_cnt); end
        IF_READY = 1'b1;
        @(negedge CLK);
        IF_READY = 1'b0;
        checks++; if (IF_PC !== 32'h4 || IM_REQ !== 1'b0) begin failures++; $display("FAIL bp_pop got=%h/%b exp=4/0", IF_PC, IM_REQ); end
        @(negedge CLK);
        checks++; if (IM_REQ !== 1'b1 || IM_ADDR !== 32'h10) begin failures++; $display("FAIL bp_refill got=%b/%h exp=1/10", IM_REQ, IM_ADDR); end
        @(negedge CLK);
        checks++; if (IM_REQ !== 1'b0 || ack_cnt !== 5 || IF_PC !== 32'h4) begin
            failures++; $display("FAIL bp_refill_done got=%b/%0d/%h exp=0/5/4", IM_REQ, ack_cnt, IF_PC); end
    endtask

    task automatic test_redirect_drain();
        int n;
        mem_wait = 3;
        IF_READY = 1'b0;
        reset_dut();
        repeat (4) @(negedge CLK);
        checks++; if (IF_VALID !== 1'b1 || IF_PC !== 32'h0 || IM_ADDR !== 32'h4) begin
            failures++; $display("FAIL dr_pre got=%b/%h/%h exp=1/0/4", IF_VALID, IF_PC, IM_ADDR); end
        BR_TAKEN  = 1'b1;
        BR_TARGET = 32'h40;
        @(negedge CLK);
        BR_TAKEN = 1'b0;
        checks++; if (IF_VALID !== 1'b0 || IM_REQ !== 1'b1 || IM_ADDR !== 32'h4) begin
            failures++; $display("FAIL dr_flush got=%b/%b/%h exp=0/1/4", IF_VALID, IM_REQ, IM_ADDR); end
        for (int k = 0; k < 2; k++) begin
            @(negedge CLK);
            checks++; if (IM_ADDR !== 32'h4) begin failures++; $display("FAIL dr_hold[%0d] got=%h exp=4", k, IM_ADDR); end
        end
        @(negedge CLK);
        checks++; if (IM_ADDR !== 32'h40 || IF_VALID !== 1'b0) begin
            failures++; $display("FAIL dr_retarget got=%h/%b exp=40/0", IM_ADDR, IF_VALID); end
        n = 0;
        while (IF_VALID !== 1'b1 && n < 12) begin
            @(negedge CLK);
            n++;
        end
        checks++; if (IF_VALID !== 1'b1) begin failures++; $display("FAIL dr_timeout got=%b exp=1", IF_VALID); end
        checks++; if (IF_PC !== 32'h40 || IF_IR !== mem_word(32'h40)) begin
            failures++; $display("FAIL dr_first_pc got=%h/%h exp=40/%h", IF_PC, IF_IR, mem_word(32'h40)); end
    endtask

    task automatic test_redirect_ack();
        mem_wait = 0;
        IF_READY = 1'b1;
        reset_dut();
        repeat (3) @(negedge CLK);
        checks++; if (IF_VALID !== 1'b1 || IF_PC !== 32'h8 || IM_ACK !== 1'b1) begin
            failures++; $display("FAIL ra_pre got=%b/%h/%b exp=1/8/1", IF_VALID, IF_PC, IM_ACK); end
        BR_TAKEN  = 1'b1;
        BR_TARGET = 32'h100;
        @(negedge CLK);
        BR_TAKEN = 1'b0;
        checks++; if (IF_VALID !== 1'b0 || IM_REQ !== 1'b1 || IM_ADDR !== 32'h100) begin
            failures++; $display("FAIL ra_flush got=%b/%b/%h exp=0/1/100", IF_VALID, IM_REQ, IM_ADDR); end
        @(negedge CLK);
        checks++; if (IF_VALID !== 1'b1 || IF_PC !== 32'h100 || IF_IR !== mem_word(32'h100)) begin
            failures++; $display("FAIL ra_target got=%b/%h/%h exp=1/100/%h", IF_VALID, IF_PC, IF_IR, mem_word(32'h100)); end
        @(negedge CLK);
        checks++; if (IF_PC !== 32'h104) begin failures++; $display("FAIL ra_next got=%h exp=104", IF_PC); end
    endtask

    task automatic test_wrap();
        reset_dut();
        @(negedge CLK);
        checks++; if (if_valid2 !== 1'b1 || if_pc2 !== 32'hFFFF_FFF8) begin
            failures++; $display("FAIL wrap_pc0 got=%b/%h exp=1/fffffff8", if_valid2, if_pc2); end
        @(negedge CLK);
        checks++; if (if_pc2 !== 32'hFFFF_FFFC || im_addr2 !== 32'h0) begin
            failures++; $display("FAIL wrap_pc1 got=%h/%h exp=fffffffc/0", if_pc2, im_addr2); end
        @(negedge CLK);
        checks++; if (if_pc2 !== 32'h0 || if_ir2 !== mem_word(32'h0)) begin
            failures++; $display("FAIL wrap_pc2 got=%h/%h exp=0/%h", if_pc2, if_ir2, mem_word(32'h0)); end
    endtask

    task automatic test_reset_midflight();
        mem_wait = 0;
        IF_READY = 1'b0;
        reset_dut();
        repeat (2) @(negedge CLK);
        checks++; if (IF_VALID !== 1'b1 || IM_REQ !== 1'b1 || IM_ADDR !== 32'h8) begin
            failures++; $display("FAIL rm_pre got=%b/%b/%h exp=1/1/8", IF_VALID, IM_REQ, IM_ADDR); end
        RST_X = 1'b0;
        #1;
        checks++; if (IF_VALID !== 1'b0 || IM_REQ !== 1'b0 || IM_ADDR !== 32'h0) begin
            failures++; $display("FAIL rm_async got=%b/%b/%h exp=0/0/0", IF_VALID, IM_REQ, IM_ADDR); end
        repeat (2) @(negedge CLK);
        RST_X = 1'b1;
        @(negedge CLK);
        checks++; if (IM_REQ !== 1'b1 || IM_ADDR !== 32'h0) begin
            failures++; $display("FAIL rm_restart got=%b/%h exp=1/0", IM_REQ, IM_ADDR); end
        @(negedge CLK);
        checks++; if (IF_VALID !== 1'b1 || IF_PC !== 32'h0) begin
            failures++; $display("FAIL rm_head got=%b/%h exp=1/0", IF_VALID, IF_PC); end
    endtask

    initial begin
        checks       = 0;
        failures     = 0;
        mem_wait     = 0;
        wait_cnt     = 0;
        full_enq_cnt = 0;
        RST_X        = 1'b0;
        IF_READY     = 1'b0;
        BR_TAKEN     = 1'b0;
        BR_TARGET    = 32'h0;
        IM_ACK       = 1'b0;
        IM_RDATA     = 32'h0;
        im_ack2      = 1'b0;
        im_rdata2    = 32'h0;

        test_reset();
        test_zero_wait();
        test_backpressure();
        test_redirect_drain();
        test_redirect_ack();
        test_wrap();
        test_reset_midflight();
        repeat (2) @(negedge CLK);
        checks++; if (full_enq_cnt !== 0) begin failures++; $display("FAIL enq_into_full got=%0d exp=0", full_enq_cnt); end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

endmodule
